// File: rtl/chess_pkg.sv
// Shared types and sizing helpers for the chess-clock control path.
package chess_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN_P1 = 3'd1,
    RUN_P2 = 3'd2,
    PAUSE  = 3'd3,
    FLAG   = 3'd4
  } state_t;

  // Bits needed to hold a counter running 0..n-1 (never less than one bit).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turn_control_if.sv
// Signal bundle between the game controls and the turn controller.
interface turn_control_if;
  logic       btn_p1;
  logic       btn_p2;
  logic       btn_pause;
  logic       set_mode;
  logic       zero1;
  logic       zero2;
  logic       tick1;
  logic       tick2;
  logic       active1;
  logic       active2;
  logic       flag1;
  logic       flag2;
  logic [2:0] state_o;

  modport master (
    output btn_p1, btn_p2, btn_pause, set_mode, zero1, zero2,
    input  tick1, tick2, active1, active2, flag1, flag2, state_o
  );

  modport slave (
    input  btn_p1, btn_p2, btn_pause, set_mode, zero1, zero2,
    output tick1, tick2, active1, active2, flag1, flag2, state_o
  );
endinterface

// File: rtl/turn_control_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press.
module btn_debounce
  import chess_pkg::*;
#(
  parameter int DEB = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);
  localparam int CW = cnt_width(DEB);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Any sample agreeing with the stable level restarts the count, so only an
  // unbroken run of DEB differing samples flips the stable level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt    <= '0;
        stable <= sync2;
        pulse  <= sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/turn_control.sv
// Turn controller for a two-player chess clock: debounced buttons, turn FSM,
// per-player decrement strobes and latched time-out flags.
module turn_control
  import chess_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DEBOUNCE_MS = 10
) (
  input logic           clk,
  input logic           rst_n,
  turn_control_if.slave bus
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DEB = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int PW  = cnt_width(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        state, next_state;
  logic          p1_pulse, p2_pulse, pause_pulse;
  logic          saved_p2;
  logic [PW-1:0] presc;
  logic          running, wrap, clear_presc, tick1_d, tick2_d;
  logic          tick1_q, tick2_q, flag1_q, flag2_q;

  btn_debounce #(.DEB(DEB)) u_deb_p1 (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_p1), .pulse(p1_pulse)
  );
  btn_debounce #(.DEB(DEB)) u_deb_p2 (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_p2), .pulse(p2_pulse)
  );
  btn_debounce #(.DEB(DEB)) u_deb_pause (
    .clk(clk), .rst_n(rst_n), .btn(bus.btn_pause), .pulse(pause_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.set_mode) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (p1_pulse)      next_state = RUN_P2;
          else if (p2_pulse) next_state = RUN_P1;
        end
        RUN_P1: begin
          if (bus.zero1)        next_state = FLAG;
          else if (pause_pulse) next_state = PAUSE;
          else if (p1_pulse)    next_state = RUN_P2;
        end
        RUN_P2: begin
          if (bus.zero2)        next_state = FLAG;
          else if (pause_pulse) next_state = PAUSE;
          else if (p2_pulse)    next_state = RUN_P1;
        end
        PAUSE: begin
          if (pause_pulse) next_state = saved_p2 ? RUN_P2 : RUN_P1;
        end
        FLAG:    next_state = FLAG;
        default: next_state = IDLE;
      endcase
    end
  end

  // A strobe only survives if the running player keeps the clock this cycle.
  always_comb begin
    running     = (state == RUN_P1) || (state == RUN_P2);
    wrap        = running && (presc == PRESC_LAST);
    clear_presc = bus.set_mode ||
                  ((next_state != state) && (state != PAUSE) &&
                   ((next_state == RUN_P1) || (next_state == RUN_P2)));
    tick1_d     = wrap && (state == RUN_P1) && (next_state == RUN_P1) && !bus.zero1;
    tick2_d     = wrap && (state == RUN_P2) && (next_state == RUN_P2) && !bus.zero2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear_presc) begin
      presc <= '0;
    end else if (running) begin
      presc <= wrap ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saved_p2 <= 1'b0;
    end else if (running && (next_state == PAUSE)) begin
      saved_p2 <= (state == RUN_P2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick1_q <= 1'b0;
      tick2_q <= 1'b0;
      flag1_q <= 1'b0;
      flag2_q <= 1'b0;
    end else begin
      tick1_q <= tick1_d;
      tick2_q <= tick2_d;
      if (bus.set_mode) begin
        flag1_q <= 1'b0;
        flag2_q <= 1'b0;
      end else begin
        if ((state == RUN_P1) && (next_state == FLAG)) flag1_q <= 1'b1;
        if ((state == RUN_P2) && (next_state == FLAG)) flag2_q <= 1'b1;
      end
    end
  end

  assign bus.tick1   = tick1_q;
  assign bus.tick2   = tick2_q;
  assign bus.flag1   = flag1_q;
  assign bus.flag2   = flag2_q;
  assign bus.active1 = (state == RUN_P1) || ((state == PAUSE) && !saved_p2);
  assign bus.active2 = (state == RUN_P2) || ((state == PAUSE) && saved_p2);
  assign bus.state_o = state;
endmodule

// File: tb/tb_turn_control.sv
// Self-checking bench for turn_control with a cycle-level behavioural model
// and directed game scenarios (DIV=1000, DEB=4).
`timescale 1ns/1ps
module tb_turn_control;
  localparam int DIV     = 1000;
  localparam int DEB     = 4;
  localparam int M_IDLE  = 0;
  localparam int M_RUN1  = 1;
  localparam int M_RUN2  = 2;
  localparam int M_PAUSE = 3;
  localparam int M_FLAG  = 4;

  logic clk = 1'b0;
  logic rst_n;

  turn_control_if bus ();

  turn_control #(.CLK_HZ(1000), .TICK_HZ(1), .DEBOUNCE_MS(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit checking = 1'b0;

  int         m_mode    = M_IDLE;
  bit         m_saved2  = 1'b0;
  int         m_elapsed = 0;
  bit         m_tick1 = 1'b0, m_tick2 = 1'b0, m_flag1 = 1'b0, m_flag2 = 1'b0;
  bit [DEB+1:0] h1 = '0, h2 = '0, hp = '0;
  bit         s1 = 1'b0, s2 = 1'b0, sp = 1'b0;
  bit         q1 = 1'b0, q2 = 1'b0, qp = 1'b0;

  // Press is accepted once the last DEB synchronised samples all disagree
  // with the accepted level; h[k] is the raw level sampled k edges ago.
  function automatic void deb_step(input bit [DEB+1:0] h, inout bit st, output bit pulse);
    bit all1 = 1'b1;
    bit all0 = 1'b1;
    for (int k = 2; k < DEB + 2; k++) begin
      if (!h[k]) all1 = 1'b0;
      if (h[k])  all0 = 1'b0;
    end
    pulse = !st && all1;
    if (!st && all1)     st = 1'b1;
    else if (st && all0) st = 1'b0;
  endfunction

  function automatic logic [8:0] model_vec();
    bit a1 = (m_mode == M_RUN1) || ((m_mode == M_PAUSE) && !m_saved2);
    bit a2 = (m_mode == M_RUN2) || ((m_mode == M_PAUSE) && m_saved2);
    return {3'(m_mode), m_tick1, m_tick2, a1, a2, m_flag1, m_flag2};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus.state_o, bus.tick1, bus.tick2, bus.active1, bus.active2,
            bus.flag1, bus.flag2};
  endfunction

  // Game rules evaluated once per clock edge; buttons use last edge's presses.
  initial begin : model
    int me;
    bit wrapped, zme, own;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = M_IDLE; m_saved2 = 1'b0; m_elapsed = 0;
        m_tick1 = 1'b0; m_tick2 = 1'b0; m_flag1 = 1'b0; m_flag2 = 1'b0;
        h1 = '0; h2 = '0; hp = '0;
        s1 = 1'b0; s2 = 1'b0; sp = 1'b0; q1 = 1'b0; q2 = 1'b0; qp = 1'b0;
      end else begin
        m_tick1 = 1'b0;
        m_tick2 = 1'b0;
        if (bus.set_mode) begin
          m_mode = M_IDLE; m_flag1 = 1'b0; m_flag2 = 1'b0; m_elapsed = 0;
        end else begin
          case (m_mode)
            M_IDLE: begin
              if (q1)      begin m_mode = M_RUN2; m_elapsed = 0; end
              else if (q2) begin m_mode = M_RUN1; m_elapsed = 0; end
            end
            M_RUN1, M_RUN2: begin
              me        = m_mode;
              zme       = (me == M_RUN1) ? bus.zero1 : bus.zero2;
              own       = (me == M_RUN1) ? q1 : q2;
              wrapped   = (m_elapsed == DIV - 1);
              m_elapsed = wrapped ? 0 : m_elapsed + 1;
              if (zme) begin
                m_mode = M_FLAG;
                if (me == M_RUN1) m_flag1 = 1'b1; else m_flag2 = 1'b1;
              end else if (qp) begin
                m_mode   = M_PAUSE;
                m_saved2 = (me == M_RUN2);
              end else if (own) begin
                m_mode    = (me == M_RUN1) ? M_RUN2 : M_RUN1;
                m_elapsed = 0;
              end else if (wrapped) begin
                if (me == M_RUN1) m_tick1 = 1'b1; else m_tick2 = 1'b1;
              end
            end
            M_PAUSE: if (qp) m_mode = m_saved2 ? M_RUN2 : M_RUN1;
            default: ;
          endcase
        end
        h1 = {h1[DEB:0], bus.btn_p1};
        h2 = {h2[DEB:0], bus.btn_p2};
        hp = {hp[DEB:0], bus.btn_pause};
        deb_step(h1, s1, q1);
        deb_step(h2, s2, q2);
        deb_step(hp, sp, qp);
      end
    end
  end

  initial begin : compare
    logic [8:0] act, req;
    forever begin
      @(negedge clk);
      if (checking && rst_n) begin
        act = dut_vec();
        req = model_vec();
        checks++;
        if (act !== req) begin
          failures++;
          if (failures <= 20)
            $display("[TB] FAIL model_compare t=%0t actual=%b required=%b", $time, act, req);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, actual, required);
    end
  endtask

  task automatic applyStimulus(input bit p1, input bit p2, input bit pause,
                               input bit sm, input bit z1, input bit z2);
    bus.btn_p1    = p1;
    bus.btn_p2    = p2;
    bus.btn_pause = pause;
    bus.set_mode  = sm;
    bus.zero1     = z1;
    bus.zero2     = z2;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(3);
    checkOutput("reset_outputs", 16'(dut_vec()), 16'h0);
    rst_n    = 1'b1;
    checking = 1'b1;
    cycles(2);

    // Start from IDLE: player 2 press hands the clock to player 1.
    applyStimulus(0, 1, 0, 0, 0, 0);
    cycles(6);
    checkOutput("idle_before_pulse", 16'(bus.state_o), 16'd0);
    cycles(1);
    checkOutput("run_p1_after_7", 16'(bus.state_o), 16'd1);
    checkOutput("active1_run", 16'({bus.active1, bus.active2}), 16'b10);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(999);
    checkOutput("first_tick1", 16'({bus.tick1, bus.tick2}), 16'b10);
    cycles(1000);
    checkOutput("second_tick1", 16'({bus.tick1, bus.tick2}), 16'b10);

    // Bouncy player-1 press: five short glitches, then a real hold.
    for (int g = 0; g < 5; g++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      cycles(3);
      applyStimulus(0, 0, 0, 0, 0, 0);
      cycles(3);
    end
    checkOutput("bounce_ignored", 16'(bus.state_o), 16'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    cycles(7);
    checkOutput("switch_to_p2", 16'(bus.state_o), 16'd2);
    cycles(5);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(995);
    checkOutput("first_tick2", 16'({bus.tick1, bus.tick2}), 16'b01);
    checkOutput("single_switch", 16'(bus.state_o), 16'd2);

    // Back to player 1, pause with 600 counts elapsed, resume later.
    applyStimulus(0, 1, 0, 0, 0, 0);
    cycles(7);
    checkOutput("back_to_p1", 16'(bus.state_o), 16'd1);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(592);
    applyStimulus(0, 0, 1, 0, 0, 0);
    cycles(7);
    checkOutput("paused", 16'({bus.state_o, bus.active1, bus.active2}), 16'b011_10);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(5000);
    checkOutput("pause_no_tick", 16'({bus.tick1, bus.tick2}), 16'b00);
    applyStimulus(0, 0, 1, 0, 0, 0);
    cycles(7);
    checkOutput("resume_p1", 16'(bus.state_o), 16'd1);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(398);
    checkOutput("tick1_not_early", 16'(bus.tick1), 16'd0);
    cycles(1);
    checkOutput("tick1_400_after_resume", 16'(bus.tick1), 16'd1);

    // Player 2 runs out of time; flag latches and ignores buttons.
    applyStimulus(1, 0, 0, 0, 0, 0);
    cycles(7);
    checkOutput("run_p2_for_flag", 16'(bus.state_o), 16'd2);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    cycles(1);
    checkOutput("flag_on_zero2", 16'({bus.state_o, bus.flag1, bus.flag2}), 16'b100_01);
    applyStimulus(1, 1, 1, 0, 0, 1);
    cycles(8);
    applyStimulus(0, 0, 0, 0, 0, 1);
    cycles(20);
    checkOutput("flag_terminal", 16'({bus.state_o, bus.flag2, bus.tick2}), 16'b100_10);
    applyStimulus(0, 0, 0, 1, 0, 1);
    cycles(1);
    checkOutput("set_mode_clears", 16'({bus.state_o, bus.flag2}), 16'b000_0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(2);

    // Pause and player-1 press land together: pause wins.
    applyStimulus(0, 1, 0, 0, 0, 0);
    cycles(7);
    checkOutput("restart_p1", 16'(bus.state_o), 16'd1);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(2);
    applyStimulus(1, 0, 1, 0, 0, 0);
    cycles(7);
    checkOutput("pause_beats_p1", 16'({bus.state_o, bus.active1}), 16'b011_1);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(9);
    applyStimulus(0, 0, 1, 0, 0, 0);
    cycles(7);
    checkOutput("resume_after_tie", 16'(bus.state_o), 16'd1);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(982);
    applyStimulus(1, 0, 0, 0, 0, 0);
    cycles(6);
    checkOutput("before_wrap_switch", 16'({bus.state_o, bus.tick1}), 16'b001_0);
    cycles(1);
    checkOutput("switch_at_wrap", 16'({bus.state_o, bus.tick1, bus.tick2}), 16'b010_00);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(20);

    // Reset mid-game with a player-2 press still being debounced.
    checkOutput("pre_reset_active2", 16'(bus.active2), 16'd1);
    applyStimulus(0, 1, 0, 0, 0, 0);
    cycles(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", 16'(dut_vec()), 16'h0);
    cycles(1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(20);
    checkOutput("pending_discarded", 16'(bus.state_o), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
